seq_det_01011: RTL and testbench

- Serial Moore-type sequence detector for the 5-bit pattern 0-1-0-1-1, in arrival order. It samples one bit per clock on `in`.
- `out` pulses for one clock each time the most recent five sampled bits equal the pattern.
- Overlapping detection; partial matches fall back correctly after a mismatch.
- A saturating match counter is provided for status/debug.
- Sits in the electronic-lock datapath between the serial key-entry input and the unlock controller.

---
 rtl/seq_det_01011.sv | 70 +++++++
 tb/tb_seq_det_01011.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_01011.sv
// seq_det_01011: Moore detector for the serial pattern 0-1-0-1-1 (arrival order) with
// overlapping detection and a saturating match counter.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rstn      - asynchronous reset, active HIGH despite the name
//   in        - serial data bit, sampled on each rising edge
//   out       - one-cycle detect pulse, high while the detector sits in S5
//   match_cnt - detections since reset, saturates at all-ones
module seq_det_01011 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // Each state names the longest input suffix that is also a pattern prefix.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // none
        S1 = 3'd1,  // "0"
        S2 = 3'd2,  // "01"
        S3 = 3'd3,  // "010"
        S4 = 3'd4,  // "0101"
        S5 = 3'd5   // "01011"
    } state_e;

    state_e state_q, state_d;

    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0:      state_d = in ? S0 : S1;
            S1:      state_d = in ? S2 : S1;
            S2:      state_d = in ? S0 : S3;
            S3:      state_d = in ? S4 : S1;
            S4:      state_d = in ? S5 : S3;
            S5:      state_d = in ? S0 : S1;
            default: state_d = S0;  // unused encodings recover to S0
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered decode of S5 so the pulse cannot glitch on multi-bit state changes.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out <= 1'b0;
        end else begin
            out <= (state_d == S5);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            match_cnt <= '0;
        end else if ((state_d == S5) && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_01011.sv
// tb_seq_det_01011: self-checking bench for seq_det_01011. Runs an 8-bit-counter instance
// and a 2-bit-counter instance side by side on the same stimulus. Expectations come from
// a hand-written vector table and from a 5-bit history model, queued when each bit is
// driven and compared one step after the sampling edge.
module tb_seq_det_01011;

    logic       clk;
    logic       rstn;
    logic       in;
    logic       out;
    logic [7:0] match_cnt;
    logic       out2;
    logic [1:0] match_cnt2;

    int checks   = 0;
    int failures = 0;

    seq_det_01011 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in),
        .out       (out),
        .match_cnt (match_cnt)
    );

    seq_det_01011 #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in),
        .out       (out2),
        .match_cnt (match_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       o;
        logic [7:0] c;
        logic [1:0] c2;
    } exp_t;

    typedef struct {
        logic       b;
        logic       o;
        logic [7:0] c;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];

    // Reference model: raw history of sampled bits, independent of any state encoding.
    logic [4:0] m_hist;
    int         m_valid;
    int         m_cnt;

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_hist  = '0;
        m_valid = 0;
        m_cnt   = 0;
    endtask

    function automatic exp_t model_step(input logic b);
        exp_t e;
        m_hist = {m_hist[3:0], b};
        if (m_valid < 5) m_valid++;
        e.o = (m_valid >= 5) && (m_hist == 5'b01011);
        if (e.o) m_cnt++;
        e.c  = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
        e.c2 = sat2(m_cnt);
        return e;
    endfunction

    // Drive one bit at the falling edge, queue its expectation, compare after the edge.
    task automatic apply(input logic b, input exp_t e, input string name);
        exp_t got;
        @(negedge clk);
        in = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({name, "_out"},  32'(out),        32'(got.o));
            check({name, "_cnt"},  32'(match_cnt),  32'(got.c));
            check({name, "_out2"}, 32'(out2),       32'(got.o));
            check({name, "_cnt2"}, 32'(match_cnt2), 32'(got.c2));
        end
    endtask

    task automatic send(input logic b, input string name);
        exp_t e;
        e = model_step(b);
        apply(b, e, name);
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n, input string name);
        for (int i = n - 1; i >= 0; i--) send(bits[i], name);
    endtask

    // Asserts reset between edges, checks it clears at once, holds 3 cycles with random
    // input, then releases just after a rising edge so the next edge samples a real bit.
    task automatic do_reset(input string name);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check({name, "_async_out"}, 32'(out),        32'd0);
        check({name, "_async_cnt"}, 32'(match_cnt),  32'd0);
        check({name, "_async_cnt2"}, 32'(match_cnt2), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check({name, "_hold_out"}, 32'(out),       32'd0);
            check({name, "_hold_cnt"}, 32'(match_cnt), 32'd0);
        end
        rstn = 1'b0;
        model_reset();
    endtask

    initial begin
        rstn = 1'b1;
        in   = 1'b0;
        model_reset();

        // Stream with detections at edges 7 and 12 (0-based bit index).
        vecs[0]  = '{1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 8'd2};
        vecs[14] = '{1'b1, 1'b0, 8'd2};
        vecs[15] = '{1'b0, 1'b0, 8'd2};

        // 1: power-on reset
        do_reset("rst_init");

        // 2: table-driven stream
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            exp_t m;
            m    = model_step(vecs[i].b);
            e.o  = vecs[i].o;
            e.c  = vecs[i].c;
            e.c2 = sat2(int'(vecs[i].c));
            check("tbl_vs_model", 32'(m.o), 32'(e.o));
            apply(vecs[i].b, e, "stream");
        end

        // 1 (cont.): asynchronous reset with a nonzero counter
        do_reset("rst_async");

        // 3: S4 --0--> S3 fallback, single detection after 7th bit
        send_seq(16'b0101011, 7, "fallback");
        check("fallback_total", 32'(match_cnt), 32'd1);

        // 4: near misses
        do_reset("rst_near");
        send_seq(16'b0101001111, 10, "near_miss");
        check("near_miss_total", 32'(match_cnt), 32'd0);

        // 5: reset mid-pattern discards the partial match
        do_reset("rst_pre_mid");
        send_seq(16'b0101, 4, "mid_pre");
        do_reset("rst_mid");
        send(1'b1, "mid_post");
        check("mid_no_detect", 32'(match_cnt), 32'd0);
        send_seq(16'b01011, 5, "mid_redetect");
        check("mid_redetect_total", 32'(match_cnt), 32'd1);

        // 6: saturation of the 2-bit counter over five separated matches
        do_reset("rst_sat");
        for (int k = 0; k < 5; k++) begin
            send_seq(16'b010111, 6, "sat");
            check("sat_cnt2", 32'(match_cnt2), 32'(sat2(k + 1)));
        end
        check("sat_cnt8", 32'(match_cnt), 32'd5);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
